serial_recv: RTL and testbench

Parametrised successor to the fixed 8-bit PS/2-style frame receiver. It takes one bit per cycle on which `i_en` is high (the bit strobe from the upstream clock-edge detector) and assembles start / data / optional parity / stop frames. Completed words are presented on a valid/ready output port. Parity, framing, timeout and overrun conditions are reported separately. It sits between the line-edge detector and the scan-code decoder.

---
 rtl/serial_recv_pkg.sv | 26 ++
 rtl/shift_in_reg.sv | 33 +++
 rtl/serial_recv.sv | 185 ++++++++++++++++++
 tb/tb_serial_recv.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_recv_pkg.sv
// Shared constants and helpers for the serial frame receiver.
package serial_recv_pkg;

  // Frame FSM state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Parity mode selectors.
  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_EVEN = 32'sd1;
  localparam int PAR_ODD  = 32'sd2;

  // Parity bit the line should carry, given the XOR of the data bits.
  function automatic logic parity_expect(input logic acc, input int mode);
    logic bit_s;
    if (mode == PAR_ODD) begin
      bit_s = ~acc;
    end else begin
      bit_s = acc;
    end
    return bit_s;
  endfunction

endpackage

// File: rtl/shift_in_reg.sv
// Serial-in parallel-out register; bit order selected by LSB_FIRST.
module shift_in_reg #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift,
  input  logic              din,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_r;

  // Take one serial bit per shift strobe, filling from the end chosen by LSB_FIRST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (clr) begin
      q_r <= '0;
    end else if (shift) begin
      if (LSB_FIRST != 32'sd0) begin
        q_r <= {din, q_r[DATA_W-1:1]};
      end else begin
        q_r <= {q_r[DATA_W-2:0], din};
      end
    end
  end

  assign q = q_r;

endmodule

// File: rtl/serial_recv.sv
// Start/data/parity/stop frame receiver with a valid/ready word output
// and one-cycle error pulses for parity, framing/timeout and overrun.
module serial_recv
  import serial_recv_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int LSB_FIRST   = 0,
  parameter int STOP_CHECK  = 1,
  parameter int TIMEOUT     = 0
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_sclr,
  input  logic              i_en,
  input  logic              i_dat,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              acc_r;
  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic              perr_r;
  logic              ferr_r;
  logic              ovr_r;

  logic [DATA_W-1:0] shift_q_s;
  logic              shift_en_s;
  logic              par_edge_s;
  logic              par_bad_s;
  logic              stop_edge_s;
  logic              stop_bad_s;
  logic              done_s;
  logic              load_s;
  logic              tmo_hit_s;

  assign shift_en_s = (state_r == ST_DATA) && i_en;

  shift_in_reg #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift (
    .clk  (clk),
    .rst_n(i_rst_n),
    .clr  (i_sclr),
    .shift(shift_en_s),
    .din  (i_dat),
    .q    (shift_q_s)
  );

  // Decode the strobes that close the parity and stop phases of a frame
  always_comb begin
    par_edge_s  = (state_r == ST_PARITY) && i_en;
    par_bad_s   = par_edge_s && (i_dat != parity_expect(acc_r, PARITY_MODE));
    stop_edge_s = (state_r == ST_STOP) && i_en;
    if (STOP_CHECK != 32'sd0) begin
      stop_bad_s = stop_edge_s && !i_dat;
    end else begin
      stop_bad_s = 1'b0;
    end
    done_s = stop_edge_s && !stop_bad_s;
    load_s = done_s && (!valid_r || i_ready);
  end

  if (TIMEOUT > 32'sd0) begin : g_tmo
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_r;

    // Count strobe-free cycles inside a frame; any strobe or leaving the frame restarts it
    always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        tmo_cnt_r <= '0;
      end else if (i_sclr) begin
        tmo_cnt_r <= '0;
      end else if (i_en || (state_r == ST_IDLE) || tmo_hit_s) begin
        tmo_cnt_r <= '0;
      end else if (tmo_cnt_r != TMO_MAX) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
    end

    // The abort fires on the edge where the idle count would reach TIMEOUT
    assign tmo_hit_s = (state_r != ST_IDLE) && !i_en && (tmo_cnt_r == TMO_LAST);
  end else begin : g_no_tmo
    assign tmo_hit_s = 1'b0;
  end

  // Frame FSM with bit counter and running data parity
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= '0;
      acc_r     <= 1'b0;
    end else if (i_sclr) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= '0;
      acc_r     <= 1'b0;
    end else if (tmo_hit_s) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_en && !i_dat) begin
            state_r   <= ST_DATA;
            bit_cnt_r <= '0;
            acc_r     <= 1'b0;
          end
        end
        ST_DATA: begin
          if (i_en) begin
            acc_r <= acc_r ^ i_dat;
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= '0;
              state_r   <= (PARITY_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (par_edge_s) begin
            state_r <= par_bad_s ? ST_IDLE : ST_STOP;
          end
        end
        ST_STOP: begin
          if (stop_edge_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output holding register, handshake and one-cycle error pulses
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else if (i_sclr) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      perr_r <= par_bad_s;
      ferr_r <= stop_bad_s || tmo_hit_s;
      ovr_r  <= done_s && valid_r && !i_ready;
      if (load_s) begin
        data_r  <= shift_q_s;
        valid_r <= 1'b1;
      end else if (valid_r && i_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign o_data       = data_r;
  assign o_valid      = valid_r;
  assign o_busy       = (state_r != ST_IDLE);
  assign o_parity_err = perr_r;
  assign o_frame_err  = ferr_r;
  assign o_overrun    = ovr_r;

endmodule

// File: tb/tb_serial_recv.sv
// Self-checking bench: two receiver configurations share one stimulus stream
// and are compared every cycle against a frame-level reference model.
module tb_serial_recv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic sclr  = 1'b0;
  logic en    = 1'b0;
  logic dat   = 1'b1;
  logic rdy   = 1'b0;

  logic [7:0] a_data, b_data;
  logic a_valid, a_busy, a_perr, a_ferr, a_ovr;
  logic b_valid, b_busy, b_perr, b_ferr, b_ovr;

  // A: MSB first, even parity, stop checked, 16-cycle timeout
  serial_recv #(.DATA_W(8), .PARITY_MODE(1), .LSB_FIRST(0), .STOP_CHECK(1), .TIMEOUT(16)) dut_a (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .i_en(en), .i_dat(dat), .i_ready(rdy),
    .o_data(a_data), .o_valid(a_valid), .o_busy(a_busy),
    .o_parity_err(a_perr), .o_frame_err(a_ferr), .o_overrun(a_ovr));

  // B: LSB first, odd parity, stop ignored, no timeout
  serial_recv #(.DATA_W(8), .PARITY_MODE(2), .LSB_FIRST(1), .STOP_CHECK(0), .TIMEOUT(0)) dut_b (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .i_en(en), .i_dat(dat), .i_ready(rdy),
    .o_data(b_data), .o_valid(b_valid), .o_busy(b_busy),
    .o_parity_err(b_perr), .o_frame_err(b_ferr), .o_overrun(b_ovr));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: configuration and per-instance frame progress.
  int cfg_par  [2] = '{1, 2};
  int cfg_lsb  [2] = '{0, 1};
  int cfg_stop [2] = '{1, 0};
  int cfg_tmo  [2] = '{16, 0};
  int         pos      [2];   // 0 = no frame, else count of frame bits taken
  int         idle_cnt [2];
  logic       dbits    [2][8];
  logic [7:0] m_data   [2];
  logic       m_valid  [2];
  logic       m_perr   [2];
  logic       m_ferr   [2];
  logic       m_ovr    [2];

  int a_perr_cnt = 0;
  logic rdy_bg = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    pos[i] = 0; idle_cnt[i] = 0;
    m_data[i] = 8'h00; m_valid[i] = 1'b0;
    m_perr[i] = 1'b0; m_ferr[i] = 1'b0; m_ovr[i] = 1'b0;
  endtask

  // One clock edge of frame reception, using the inputs sampled at that edge.
  task automatic model_step(input int i);
    logic       load;
    logic [7:0] word;
    int         ones;
    load = 1'b0; word = 8'h00;
    m_perr[i] = 1'b0; m_ferr[i] = 1'b0; m_ovr[i] = 1'b0;
    if (sclr) begin
      model_reset(i);
    end else begin
      if (en) begin
        idle_cnt[i] = 0;
        if (pos[i] == 0) begin
          if (dat == 1'b0) pos[i] = 1;
        end else if (pos[i] <= 8) begin
          dbits[i][pos[i]-1] = dat;
          pos[i]++;
        end else if (cfg_par[i] != 0 && pos[i] == 9) begin
          // even: total ones incl. parity bit is even; odd: total is odd
          ones = int'(dat);
          for (int k = 0; k < 8; k++) ones += int'(dbits[i][k]);
          if ((ones % 2) != ((cfg_par[i] == 1) ? 0 : 1)) begin
            m_perr[i] = 1'b1;
            pos[i] = 0;
          end else begin
            pos[i]++;
          end
        end else begin
          pos[i] = 0;
          if (cfg_stop[i] != 0 && dat == 1'b0) begin
            m_ferr[i] = 1'b1;
          end else begin
            load = 1'b1;
            for (int k = 0; k < 8; k++) word[(cfg_lsb[i] != 0) ? k : 7 - k] = dbits[i][k];
          end
        end
      end else if (pos[i] != 0 && cfg_tmo[i] != 0) begin
        idle_cnt[i]++;
        if (idle_cnt[i] == cfg_tmo[i]) begin
          pos[i] = 0; idle_cnt[i] = 0; m_ferr[i] = 1'b1;
        end
      end
      if (load) begin
        if (!m_valid[i] || rdy) begin
          m_data[i] = word; m_valid[i] = 1'b1;
        end else begin
          m_ovr[i] = 1'b1;
        end
      end else if (m_valid[i] && rdy) begin
        m_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("a_data",  a_data,  m_data[0]);
    check_eq("a_valid", a_valid, m_valid[0]);
    check_eq("a_busy",  a_busy,  pos[0] != 0);
    check_eq("a_perr",  a_perr,  m_perr[0]);
    check_eq("a_ferr",  a_ferr,  m_ferr[0]);
    check_eq("a_ovr",   a_ovr,   m_ovr[0]);
    check_eq("b_data",  b_data,  m_data[1]);
    check_eq("b_valid", b_valid, m_valid[1]);
    check_eq("b_busy",  b_busy,  pos[1] != 0);
    check_eq("b_perr",  b_perr,  m_perr[1]);
    check_eq("b_ferr",  b_ferr,  m_ferr[1]);
    check_eq("b_ovr",   b_ovr,   m_ovr[1]);
  endtask

  // Drive one cycle of inputs from a negedge, step the model at the posedge,
  // and compare at the following negedge.
  task automatic cycle(input logic e, input logic d, input logic r, input logic s);
    en = e; dat = d; rdy = r; sclr = s;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
    if (a_perr === 1'b1) a_perr_cnt++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic r_stop);
    cycle(1'b1, 1'b0, rdy_bg, 1'b0);
    for (int k = 7; k >= 0; k--) cycle(1'b1, d[k], rdy_bg, 1'b0);
    cycle(1'b1, p, rdy_bg, 1'b0);
    cycle(1'b1, s, r_stop, 1'b0);
  endtask

  task automatic clear_all();
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic [10:0] fbits;
    logic [7:0]  rd;
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    compare_all();                     // outputs held at zero during reset
    rst_n = 1'b1;

    // Default frame 0xA5, even parity 0
    clear_all();
    rdy_bg = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    check_eq("t1_data",  a_data,  8'hA5);
    check_eq("t1_valid", a_valid, 1'b1);
    check_eq("t1_ferr",  a_ferr,  1'b0);

    // LSB first, odd parity: expect 0x1C on B
    clear_all();
    send_frame(8'b0011_1000, 1'b0, 1'b1, 1'b1);
    check_eq("t2_data",  b_data,  8'h1C);
    check_eq("t2_valid", b_valid, 1'b1);

    // Parity error then a good 0x3C frame
    clear_all();
    a_perr_cnt = 0;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
    check_eq("t3_perr_cnt", a_perr_cnt, 1);
    check_eq("t3_valid",    a_valid,    1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    check_eq("t3_data",     a_data,     8'h3C);

    // Bad stop bit
    clear_all();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check_eq("t4_ferr",  a_ferr,  1'b1);
    check_eq("t4_valid", a_valid, 1'b0);
    check_eq("t4_busy",  a_busy,  1'b0);

    // Timeout after start + 4 data bits
    clear_all();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, k[0], 1'b1, 1'b0);
    repeat (15) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t5_busy15", a_busy, 1'b1);
    check_eq("t5_ferr15", a_ferr, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t5_ferr",   a_ferr, 1'b1);
    check_eq("t5_busy",   a_busy, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    check_eq("t5_data",   a_data, 8'h5A);

    // Overrun with consumer stalled, then accepted on the second stop edge
    clear_all();
    rdy_bg = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check_eq("t6_data", a_data, 8'h11);
    check_eq("t6_ovr",  a_ovr,  1'b1);
    clear_all();
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    check_eq("t6b_data", a_data, 8'h22);
    check_eq("t6b_ovr",  a_ovr,  1'b0);

    // Async reset mid-frame clears outputs without a clock edge
    rdy_bg = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare_all();
    check_eq("rst_busy",  a_busy,  1'b0);
    check_eq("rst_valid", a_valid, 1'b0);
    check_eq("rst_data",  a_data,  8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized frames with gaps, bad parity/stop, stalls and clears
    for (int f = 0; f < 250; f++) begin
      rd = 8'($urandom);
      fbits[10] = 1'b0;
      fbits[9:2] = rd;
      fbits[1] = (^rd) ^ (($urandom % 4) == 0);
      fbits[0] = (($urandom % 8) != 0);
      repeat ($urandom_range(0, 3)) cycle(1'($urandom), 1'b1, 1'(($urandom % 4) != 0), 1'b0);
      for (int k = 10; k >= 0; k--) begin
        if (($urandom % 20) == 0) begin
          repeat ($urandom_range(10, 20)) cycle(1'b0, 1'($urandom), 1'(($urandom % 4) != 0), 1'b0);
        end
        if (($urandom % 100) == 0) begin
          cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end
        cycle(1'b1, fbits[k], 1'(($urandom % 4) != 0), 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
